// File: rtl/multicycle_cu24.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 24-bit CPU datapath.
// Optional perf counters (InstrCount, CycleCount) under `MCU24_PERF_CNT_EN.
module multicycle_cu24 #(
  parameter int CNT_W = 24
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [3:0]       opcode,
  input  logic             IMemReady,
  input  logic             DMemReady,
  output logic             IMemReq,
  output logic             DMemReq,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegDst,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic [2:0]       State,
  output logic             Halted,
  output logic             IllegalOp
`ifdef MCU24_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] InstrCount,
  output logic [CNT_W-1:0] CycleCount
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_IMM = 2'b11;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t     state_q;
  state_t     state_d;
  logic [3:0] op_q;

  logic is_r;
  logic is_i;
  logic is_lw;
  logic is_sw;
  logic is_beq;

  assign is_r   = (op_q == 4'h0);
  assign is_i   = (op_q >= 4'h1) && (op_q <= 4'h7);
  assign is_lw  = (op_q == 4'h8);
  assign is_sw  = (op_q == 4'h9);
  assign is_beq = (op_q == 4'hA);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_FETCH;
      op_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  assign State = state_q;

  always_comb begin
    state_d   = state_q;
    IMemReq   = 1'b0;
    DMemReq   = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegDst    = 1'b0;
    Branch    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = ALU_ADD;
    Halted    = 1'b0;
    IllegalOp = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IMemReq = 1'b1;
        if (IMemReady) begin
          // no IR/PC load may escape while reset is held
          IRWrite = Reset_n;
          PCWrite = Reset_n;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (opcode == 4'hF) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_r: begin
            RegDst  = 1'b1;
            ALUOp   = ALU_FN;
            state_d = S_WB;
          end
          is_i: begin
            ALUSrc  = 1'b1;
            ALUOp   = ALU_IMM;
            state_d = S_WB;
          end
          is_lw, is_sw: begin
            ALUSrc  = 1'b1;
            ALUOp   = ALU_ADD;
            state_d = S_MEM;
          end
          is_beq: begin
            ALUOp   = ALU_SUB;
            Branch  = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            IllegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        DMemReq  = 1'b1;
        ALUSrc   = 1'b1;
        ALUOp    = ALU_ADD;
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (DMemReady) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemToReg = is_lw;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

`ifdef MCU24_PERF_CNT_EN
  logic retire;

  assign retire = ((state_q == S_EXEC) ||
                   (state_q == S_MEM)  ||
                   (state_q == S_WB))  &&
                  (state_d == S_FETCH);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      InstrCount <= '0;
      CycleCount <= '0;
    end else begin
      if (state_q != S_HALT) begin
        CycleCount <= CycleCount + 1'b1;
      end
      if (retire) begin
        InstrCount <= InstrCount + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_cu24.sv
// Randomized bench for multicycle_cu24 against a per-instruction
// cycle-script reference model.
module tb_multicycle_cu24;

  localparam int CW = 4;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic [3:0]    opcode;
  logic          IMemReady;
  logic          DMemReady;
  logic          IMemReq, DMemReq, IRWrite, PCWrite;
  logic          RegDst, Branch, MemRead, MemWrite;
  logic          RegWrite, MemToReg, ALUSrc;
  logic [1:0]    ALUOp;
  logic [2:0]    State;
  logic          Halted, IllegalOp;
`ifdef MCU24_PERF_CNT_EN
  logic [CW-1:0] InstrCount, CycleCount;
`endif

  multicycle_cu24 #(.CNT_W(CW)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .opcode    (opcode),
    .IMemReady (IMemReady),
    .DMemReady (DMemReady),
    .IMemReq   (IMemReq),
    .DMemReq   (DMemReq),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegDst    (RegDst),
    .Branch    (Branch),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .MemToReg  (MemToReg),
    .ALUSrc    (ALUSrc),
    .ALUOp     (ALUOp),
    .State     (State),
    .Halted    (Halted),
    .IllegalOp (IllegalOp)
`ifdef MCU24_PERF_CNT_EN
    ,
    .InstrCount(InstrCount),
    .CycleCount(CycleCount)
`endif
  );

  always #5 Clock = ~Clock;

  localparam logic [14:0] IMQ  = 15'h4000;
  localparam logic [14:0] DMQ  = 15'h2000;
  localparam logic [14:0] IRW  = 15'h1000;
  localparam logic [14:0] PCW  = 15'h0800;
  localparam logic [14:0] RDST = 15'h0400;
  localparam logic [14:0] BR   = 15'h0200;
  localparam logic [14:0] MRD  = 15'h0100;
  localparam logic [14:0] MWR  = 15'h0080;
  localparam logic [14:0] RW   = 15'h0040;
  localparam logic [14:0] M2R  = 15'h0020;
  localparam logic [14:0] ASRC = 15'h0010;
  localparam logic [14:0] AFN  = 15'h0008;
  localparam logic [14:0] AIM  = 15'h000C;
  localparam logic [14:0] ASUB = 15'h0004;
  localparam logic [14:0] HLT  = 15'h0002;
  localparam logic [14:0] ILL  = 15'h0001;

  wire [17:0] obs = {State, IMemReq, DMemReq, IRWrite, PCWrite,
                     RegDst, Branch, MemRead, MemWrite, RegWrite,
                     MemToReg, ALUSrc, ALUOp, Halted, IllegalOp};

  int checks = 0;
  int errors = 0;
  int cyc_model = 0;
  int instr_model = 0;

  logic [17:0] eq[$];
  int          imq[$];
  int          dmq[$];
  bit          decq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ev(input int st, input logic [14:0] f);
    logic [2:0] s;
    s = st[2:0];
    return {s, f};
  endfunction

  // imr/dmr: 0 or 1 drives that level, 2 drives a random level
  task automatic add(input int st, input logic [14:0] f,
                     input int imr, input int dmr, input bit dec);
    eq.push_back(ev(st, f));
    imq.push_back(imr);
    dmq.push_back(dmr);
    decq.push_back(dec);
  endtask

  task automatic chk_cnt(input string tag);
`ifdef MCU24_PERF_CNT_EN
    chk({tag, " cyc"}, 32'(CycleCount), 32'(cyc_model % (1 << CW)));
    chk({tag, " ins"}, 32'(InstrCount), 32'(instr_model % (1 << CW)));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic do_reset();
    Reset_n   = 1'b0;
    IMemReady = 1'b1;
    DMemReady = 1'b1;
    #1;
    chk("rst async", 32'(obs), 32'(ev(0, IMQ)));
    cyc_model   = 0;
    instr_model = 0;
    @(negedge Clock);
    chk("rst held", 32'(obs), 32'(ev(0, IMQ)));
    chk_cnt("rst");
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
  endtask

  // Builds the expected cycle script for one instruction and plays it.
  task automatic run_instr(input logic [3:0] op, input int iw,
                           input int dw, input int abort,
                           output bit stopped);
    eq.delete(); imq.delete(); dmq.delete(); decq.delete();
    stopped = 0;
    for (int k = 0; k < iw; k++) add(0, IMQ, 0, 2, 0);
    add(0, IMQ | IRW | PCW, 1, 2, 0);
    add(1, 15'h0, 2, 2, 1);
    if (op == 4'hF) begin
      for (int k = 0; k < 4; k++) add(5, HLT, 2, 2, 0);
    end else if (op == 4'h0) begin
      add(2, RDST | AFN, 2, 2, 0);
      add(4, RW, 2, 2, 0);
    end else if (op <= 4'h7) begin
      add(2, ASRC | AIM, 2, 2, 0);
      add(4, RW, 2, 2, 0);
    end else if (op == 4'h8 || op == 4'h9) begin
      add(2, ASRC, 2, 2, 0);
      for (int k = 0; k < dw; k++)
        add(3, DMQ | ASRC | ((op == 4'h8) ? MRD : MWR), 2, 0, 0);
      add(3, DMQ | ASRC | ((op == 4'h8) ? MRD : MWR), 2, 1, 0);
      if (op == 4'h8) add(4, RW | M2R, 2, 2, 0);
    end else if (op == 4'hA) begin
      add(2, BR | ASUB, 2, 2, 0);
    end else begin
      add(2, ILL, 2, 2, 0);
    end
    for (int i = 0; i < eq.size(); i++) begin
      if (abort > 0 && i == abort) begin
        stopped = 1;
        return;
      end
      opcode    = decq[i] ? op : 4'($urandom);
      IMemReady = (imq[i] == 2) ? 1'($urandom) : 1'(imq[i]);
      DMemReady = (dmq[i] == 2) ? 1'($urandom) : 1'(dmq[i]);
      @(negedge Clock);
      chk($sformatf("op%0h c%0d", op, i), 32'(obs), 32'(eq[i]));
      if (i == 0 || eq[i][17:15] == 3'd5) chk_cnt($sformatf("op%0h c%0d", op, i));
      @(posedge Clock);
      #1;
      if (eq[i][17:15] != 3'd5) cyc_model++;
    end
    if (op == 4'hF) stopped = 1;
    else instr_model++;
  endtask

  initial begin
    bit st;
    logic [3:0] op;
    int ab;
    opcode = 4'h0;
    do_reset();
    run_instr(4'h0, 0, 0, 0, st);
    run_instr(4'h8, 0, 3, 0, st);
    run_instr(4'h9, 2, 0, 0, st);
    run_instr(4'hC, 0, 0, 0, st);
    run_instr(4'hA, 0, 0, 0, st);
    run_instr(4'h3, 1, 0, 0, st);
    do_reset();
    for (int n = 0; n < 17; n++) run_instr(4'h0, 0, 0, 0, st);
    @(negedge Clock);
    chk_cnt("r17");
    @(posedge Clock);
    #1;
    do_reset();
    run_instr(4'hF, 0, 0, 0, st);
    do_reset();
    run_instr(4'h8, 1, 3, 4, st);
    do_reset();
    for (int n = 0; n < 120; n++) begin
      op = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 19) == 0) op = 4'hF;
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), ab, st);
      if (st) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
